// File: rtl/tone_scheduler_pkg.sv
// Shared types and constants for the tone scheduler slice.
package tone_pkg;

    localparam int unsigned CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP
    } tone_state_t;

    typedef enum logic {
        REQ_SFX = 1'b0,
        REQ_MEL = 1'b1
    } req_id_t;

endpackage

// File: rtl/tone_scheduler_tick_gen.sv
// Prescaler emitting a one-cycle tick every TICK_DIV clocks.
// restart_i zeroes the prescaler so the first tick lands TICK_DIV cycles later.
module tick_gen
    import tone_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick_o = !restart_i && (cnt_q == LAST);

    // Next prescaler value: restart wins, otherwise wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tone_scheduler.sv
// Arbitrates the tone divider between the sfx and melody requesters.
// Fixed priority to sfx; each note plays for dur ticks then a silent gap.
// Optional macro TONE_SCHEDULER_PREEMPT_EN lets an sfx request cut a
// melody note short.
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned GAP_TICKS = 20,
    parameter int unsigned DUR_W     = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             sfx_valid_i,
    input  logic [31:0]      sfx_divisor_i,
    input  logic [DUR_W-1:0] sfx_dur_i,
    output logic             sfx_ready_o,
    input  logic             mel_valid_i,
    input  logic [31:0]      mel_divisor_i,
    input  logic [DUR_W-1:0] mel_dur_i,
    output logic             mel_ready_o,
    output logic [31:0]      divisor_out_o,
    output logic             tone_en_o,
    output logic             busy_o,
    output logic             grant_id_o,
    output logic             done_o,
    output logic             aborted_o
);

    localparam logic [DUR_W-1:0] GAP_LD = DUR_W'(GAP_TICKS);
    localparam logic [DUR_W-1:0] ONE    = DUR_W'(1);

    tone_state_t      state_q;
    req_id_t          grant_q;
    logic [31:0]      div_q;
    logic             tone_q;
    logic             done_q;
    logic [DUR_W-1:0] cnt_q;

    logic             idle;
    logic             sfx_hs;
    logic             mel_hs;
    logic             accept;
    logic             tick;
    logic [31:0]      req_div;
    logic [DUR_W-1:0] req_dur;
    req_id_t          req_id;

    assign idle = (state_q == IDLE);

`ifdef TONE_SCHEDULER_PREEMPT_EN
    logic preempt_ok;
    logic abort_pulse;

    // A melody note in PLAY or GAP can be displaced by sfx.
    assign preempt_ok  = !idle && (grant_q == REQ_MEL);
    assign sfx_ready_o = idle || preempt_ok;
    // Only a cut during PLAY reports done; a GAP cut already had its done.
    assign abort_pulse = sfx_hs && preempt_ok && (state_q == PLAY);
    assign done_o      = done_q || abort_pulse;
    assign aborted_o   = abort_pulse;
`else
    assign sfx_ready_o = idle;
    assign done_o      = done_q;
    assign aborted_o   = 1'b0;
`endif

    assign mel_ready_o   = idle && !sfx_valid_i;
    assign sfx_hs        = sfx_valid_i && sfx_ready_o;
    assign mel_hs        = mel_valid_i && mel_ready_o;
    assign accept        = sfx_hs || mel_hs;

    assign busy_o        = !idle;
    assign divisor_out_o = div_q;
    assign tone_en_o     = tone_q;
    assign grant_id_o    = grant_q;

    // Select the winning request fields.
    always_comb begin
        req_div = mel_divisor_i;
        req_dur = mel_dur_i;
        req_id  = REQ_MEL;
        if (sfx_hs) begin
            req_div = sfx_divisor_i;
            req_dur = sfx_dur_i;
            req_id  = REQ_SFX;
        end
    end

    // Prescaler restarts on every accept so PLAY lasts exactly dur*TICK_DIV.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i     (clk_i),
        .rst_ni    (reset_i),
        .restart_i (accept),
        .tick_o    (tick)
    );

    // Scheduler FSM with registered outputs; the tick counter counts down.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            grant_q <= REQ_SFX;
            div_q   <= '0;
            tone_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                grant_q <= req_id;
                div_q   <= req_div;
                if (req_dur != '0) begin
                    state_q <= PLAY;
                    cnt_q   <= req_dur;
                    tone_q  <= (req_div != '0);
                end else begin
                    tone_q <= 1'b0;
                    done_q <= 1'b1;
                    if (GAP_TICKS != 0) begin
                        state_q <= GAP;
                        cnt_q   <= GAP_LD;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
            end else begin
                case (state_q)
                    PLAY: begin
                        if (tick) begin
                            if (cnt_q == ONE) begin
                                // Divisor held so the divider keeps running.
                                tone_q <= 1'b0;
                                done_q <= 1'b1;
                                if (GAP_TICKS != 0) begin
                                    state_q <= GAP;
                                    cnt_q   <= GAP_LD;
                                end else begin
                                    state_q <= IDLE;
                                    cnt_q   <= '0;
                                end
                            end else begin
                                cnt_q <= cnt_q - ONE;
                            end
                        end
                    end
                    GAP: begin
                        if (tick) begin
                            if (cnt_q == ONE) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q - ONE;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed bench for tone_scheduler (TICK_DIV=4, GAP_TICKS=2, default build).
module tb_tone_scheduler;

    localparam int TD  = 4;
    localparam int GT  = 2;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sfx_valid = 1'b0;
    logic [31:0]   sfx_divisor = '0;
    logic [DW-1:0] sfx_dur = '0;
    logic          mel_valid = 1'b0;
    logic [31:0]   mel_divisor = '0;
    logic [DW-1:0] mel_dur = '0;
    logic          sfx_ready, mel_ready, tone_en, busy, grant_id, done, aborted;
    logic [31:0]   divisor_out;

    tone_scheduler #(
        .TICK_DIV  (TD),
        .GAP_TICKS (GT),
        .DUR_W     (DW)
    ) dut (
        .clk_i         (clk),
        .reset_i       (rst_n),
        .sfx_valid_i   (sfx_valid),
        .sfx_divisor_i (sfx_divisor),
        .sfx_dur_i     (sfx_dur),
        .sfx_ready_o   (sfx_ready),
        .mel_valid_i   (mel_valid),
        .mel_divisor_i (mel_divisor),
        .mel_dur_i     (mel_dur),
        .mel_ready_o   (mel_ready),
        .divisor_out_o (divisor_out),
        .tone_en_o     (tone_en),
        .busy_o        (busy),
        .grant_id_o    (grant_id),
        .done_o        (done),
        .aborted_o     (aborted)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: remaining PLAY / GAP time in clock cycles.
    int          m_play = 0;
    int          m_gap  = 0;
    logic [31:0] m_div  = '0;
    logic        m_tone = 1'b0;
    logic        m_gid  = 1'b0;
    logic        m_done = 1'b0;
    int          cyc = 0;
    int          m_sfx_n = 0, m_mel_n = 0;
    int          m_sfx_cyc = 0, m_mel_cyc = 0;

    function automatic logic m_idle();
        return (m_play == 0) && (m_gap == 0);
    endfunction

    // Model update on each clock edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_play <= 0; m_gap <= 0; m_div <= '0; m_tone <= 1'b0;
            m_gid <= 1'b0; m_done <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            m_done <= 1'b0;
            if (m_idle() && (sfx_valid || mel_valid)) begin
                if (sfx_valid) begin
                    m_gid <= 1'b0; m_div <= sfx_divisor;
                    m_sfx_n <= m_sfx_n + 1; m_sfx_cyc <= cyc;
                    if (sfx_dur != 0) begin
                        m_play <= int'(sfx_dur) * TD; m_tone <= (sfx_divisor != 0);
                    end else begin
                        m_done <= 1'b1; m_gap <= GT * TD; m_tone <= 1'b0;
                    end
                end else begin
                    m_gid <= 1'b1; m_div <= mel_divisor;
                    m_mel_n <= m_mel_n + 1; m_mel_cyc <= cyc;
                    if (mel_dur != 0) begin
                        m_play <= int'(mel_dur) * TD; m_tone <= (mel_divisor != 0);
                    end else begin
                        m_done <= 1'b1; m_gap <= GT * TD; m_tone <= 1'b0;
                    end
                end
            end else if (m_play > 0) begin
                m_play <= m_play - 1;
                if (m_play == 1) begin
                    m_tone <= 1'b0; m_done <= 1'b1; m_gap <= GT * TD;
                end
            end else if (m_gap > 0) begin
                m_gap <= m_gap - 1;
            end
        end
    end

    // Per-cycle compare plus activity counters used by the literal checks.
    logic cmp_en = 1'b0;
    int   n_tone = 0, n_busy = 0, n_done = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",      busy,        !m_idle());
            chk("sfx_ready", sfx_ready,   m_idle());
            chk("mel_ready", mel_ready,   m_idle() && !sfx_valid);
            chk("tone_en",   tone_en,     m_tone);
            chk("divisor",   divisor_out, m_div);
            chk("grant_id",  grant_id,    m_gid);
            chk("done",      done,        m_done);
            chk("aborted",   aborted,     1'b0);
            if (tone_en) n_tone++;
            if (busy)    n_busy++;
            if (done)    n_done++;
        end
    end

    task automatic send_sfx(input logic [31:0] d, input logic [DW-1:0] u);
        int  n0;
        bit  ok;
        ok = 1'b0;
        @(posedge clk); #2;
        n0 = m_sfx_n;
        sfx_valid = 1'b1; sfx_divisor = d; sfx_dur = u;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (m_sfx_n != n0) ok = 1'b1;
        end
        #1 sfx_valid = 1'b0;
        chk("sfx_accept_in_time", ok, 1'b1);
    endtask

    task automatic send_mel(input logic [31:0] d, input logic [DW-1:0] u);
        int  n0;
        bit  ok;
        ok = 1'b0;
        @(posedge clk); #2;
        n0 = m_mel_n;
        mel_valid = 1'b1; mel_divisor = d; mel_dur = u;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (m_mel_n != n0) ok = 1'b1;
        end
        #1 mel_valid = 1'b0;
        chk("mel_accept_in_time", ok, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #2;
            if (m_idle()) ok = 1'b1;
        end
        chk("idle_in_time", ok, 1'b1);
    endtask

    int t0, b0, d0;

    initial begin
        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_divisor",   divisor_out, 32'd0);
        chk("rst_tone_en",   tone_en,     1'b0);
        chk("rst_busy",      busy,        1'b0);
        chk("rst_done",      done,        1'b0);
        chk("rst_sfx_ready", sfx_ready,   1'b1);
        chk("rst_mel_ready", mel_ready,   1'b1);

        // Single melody note: 12 tone cycles, 20 busy cycles, one done.
        t0 = n_tone; b0 = n_busy; d0 = n_done;
        send_mel(32'd1000, 16'd3);
        wait_idle();
        chk("mel_tone_cycles", n_tone - t0, 12);
        chk("mel_busy_cycles", n_busy - b0, 20);
        chk("mel_done_pulses", n_done - d0, 1);

        // Simultaneous requests: sfx first, mel 13 cycles later.
        fork
            send_sfx(32'd500, 16'd1);
            send_mel(32'd700, 16'd2);
        join
        chk("prio_sfx_first", m_mel_cyc - m_sfx_cyc, (1 + GT) * TD + 1);
        wait_idle();

        // Rest note: silent but busy for PLAY + GAP.
        t0 = n_tone; b0 = n_busy; d0 = n_done;
        send_mel(32'd0, 16'd2);
        wait_idle();
        chk("rest_tone_cycles", n_tone - t0, 0);
        chk("rest_busy_cycles", n_busy - b0, 16);
        chk("rest_done_pulses", n_done - d0, 1);

        // Zero duration: no PLAY, gap only.
        t0 = n_tone; b0 = n_busy; d0 = n_done;
        send_sfx(32'd1234, 16'd0);
        wait_idle();
        chk("dur0_tone_cycles", n_tone - t0, 0);
        chk("dur0_busy_cycles", n_busy - b0, 8);
        chk("dur0_done_pulses", n_done - d0, 1);

        // Reset in the middle of PLAY.
        d0 = n_done;
        send_mel(32'd1000, 16'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_tone", tone_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tone", tone_en, 1'b0);
        chk("async_rst_div",  divisor_out, 32'd0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_gid",  grant_id, 1'b0);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("reset_no_done", n_done - d0, 0);

        // sfx arriving mid-melody waits for IDLE.
        fork
            send_mel(32'd2000, 16'd10);
            begin
                repeat (7) @(posedge clk);
                send_sfx(32'd3000, 16'd1);
            end
        join
        chk("sfx_waits_idle", m_sfx_cyc - m_mel_cyc, (10 + GT) * TD + 1);
        wait_idle();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/tone_scheduler.md
Name: tone_scheduler

Overview:
Shares the single tone clock divider between two requesters: the sound-effect source (sfx) and the melody player (mel). Each request is one note: a divider value plus a duration in milliseconds. The block grants requests by fixed priority, drives the divisor and tone enable for the note's exact duration, then inserts a silent gap. It sits between the game FSM / melody ROM reader and the clock divider feeding the speaker pin.

Parameters:
TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz); benches use 4
GAP_TICKS, 20, silent ticks inserted after every note; 0 = no gap
DUR_W, 16, width of the duration fields

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
sfx_valid  in  1  sfx note request
sfx_divisor  in  32  sfx divider value; 0 = rest
sfx_dur  in  DUR_W  sfx duration in ticks
sfx_ready  out  1  sfx request accepted this cycle when high with valid
mel_valid  in  1  melody note request
mel_divisor  in  32  melody divider value; 0 = rest
mel_dur  in  DUR_W  melody duration in ticks
mel_ready  out  1  melody handshake
divisor_out  out  32  to divider divisor input
tone_en  out  1  high = divider output routed to speaker
busy  out  1  state != IDLE
grant_id  out  1  0 = sfx, 1 = mel; owner of the current or last note
done  out  1  one-cycle pulse when a note's PLAY phase ends
aborted  out  1  qualifies done; 1 = note cut short (PREEMPT_EN only)

Behaviour:
- States: IDLE, PLAY, GAP. Asynchronous reset (reset low) forces IDLE, divisor_out=0, tone_en=0, grant_id=0, done=0, aborted=0 and clears the counters.
- Ready signals are combinational: sfx_ready = (state==IDLE); mel_ready = (state==IDLE) && !sfx_valid. Fixed priority goes to sfx. Both ready signals read 1 out of reset.
- Handshake: valid && ready at a clk edge. A requester must hold valid, divisor and dur stable until accepted.
- On accept with dur != 0:
  - next cycle state=PLAY, divisor_out=req divisor, tone_en=(divisor != 0), grant_id updated.
  - The prescaler and tick counter restart at accept, so PLAY lasts exactly dur*TICK_DIV cycles.
- On accept with dur == 0: no PLAY phase. done pulses the next cycle, tone_en stays 0, and the state goes to GAP, or to IDLE if GAP_TICKS=0.
- PLAY exit:
  - tone_en=0 and divisor_out is held, so the divider keeps running and avoids a reload glitch.
  - done=1 for one cycle with aborted=0.
  - Enter GAP for GAP_TICKS*TICK_DIV cycles, or enter IDLE directly if GAP_TICKS=0.
- GAP exit: IDLE. A request already pending is accepted in that first IDLE cycle.
- Minimum note-to-note spacing is (dur+GAP_TICKS)*TICK_DIV+1 cycles.
- Arithmetic:
  - Prescaler width is $clog2(TICK_DIV).
  - The tick counter is DUR_W bits and counts down, so it never wraps.
  - dur = all-ones is legal (65535 ms).
- Requests arriving during PLAY/GAP wait. There is no queueing beyond the requester's held valid.

Optional Feature:
Macro TONE_SCHEDULER_PREEMPT_EN.
- Defined:
  - While a mel note is in PLAY or GAP, sfx_ready=1.
  - An sfx handshake ends the mel note that cycle: done=1, aborted=1, grant_id=1 on that pulse.
  - Next cycle PLAY starts the sfx note with counters restarted.
  - An sfx note is never preempted.
  - An sfx accept during mel GAP aborts silently: no done, because done was already issued.
- Undefined: sfx_ready = (state==IDLE), and aborted is tied to 0.

Decomposition:
Package tone_pkg holds:
- state enum typedef tone_state_t {IDLE, PLAY, GAP}
- requester id typedef req_id_t with constants REQ_SFX=0, REQ_MEL=1
- constant CLK_HZ=50_000_000

Sub-module tick_gen (prescaler producing a one-cycle tick every TICK_DIV cycles, with synchronous restart input) is instantiated once.

Test Plan (TICK_DIV=4, GAP_TICKS=2):
- Reset: hold reset low 3 cycles, release -> divisor_out=0, tone_en=0, busy=0, done=0, sfx_ready=1, mel_ready=1.
- mel note divisor=1000, dur=3 -> tone_en high exactly 12 cycles with divisor_out=1000, done pulse at PLAY end, then busy for 8 more cycles, then idle.
- sfx and mel valid same cycle -> sfx granted (grant_id=0), mel_ready=0; mel accepted on the first IDLE cycle after sfx gap.
- Rest note divisor=0, dur=2 -> tone_en stays 0 for 8 cycles, busy=1, done pulses; dur=0 -> done next cycle, no PLAY.
- Reset asserted mid-PLAY (cycle 5 of 12) -> outputs return to reset values immediately; no done pulse.
- PREEMPT_EN: mel dur=10 playing, sfx valid at cycle 6 -> done=1/aborted=1/grant_id=1, next cycle divisor_out=sfx value, tone_en for sfx_dur*4 cycles; without the macro, sfx waits for IDLE.
